// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and a valid/ready output register
module keypad_scanner #(
  parameter int TICK_DIV       = 30000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk_in,
  input  logic       rst,
  output logic [3:0] col_o,
  input  logic [3:0] row_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic       key_held_o,
  output logic       overflow_o,
  input  logic       clr_overflow_i
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam bit ONE = DEBOUNCE_TICKS == 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 2);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2, RELEASE = 2'd3;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] cnt;
  logic [1:0] st, c, r, low;
  logic [3:0] rs_m, rs, code;
  logic tick, done, acc;
  assign tick = tcnt == TW'(TICK_DIV - 1);
  assign low = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
  // the detecting tick counts as the first stable tick, so the last compare is DEBOUNCE_TICKS-2
  assign done = ONE || cnt == LAST;
  assign acc = tick && ((st == SCAN && rs != 4'hF && ONE) || (st == DEBOUNCE && !rs[r] && done));
  assign code = {st == SCAN ? low : r, c};
  assign col_o = ~(4'b1 << c);
  assign key_held_o = st == HELD || st == RELEASE;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      rs_m <= 4'hF;
      rs <= 4'hF;
      tcnt <= '0;
    end else begin
      rs_m <= row_i;
      rs <= rs_m;
      tcnt <= tick ? '0 : tcnt + 1'b1;
    end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      st <= SCAN;
      c <= 2'd0;
      r <= 2'd0;
      cnt <= '0;
    end else if (tick)
      case (st)
        SCAN:
          if (rs != 4'hF) begin
            r <= low;
            cnt <= '0;
            st <= ONE ? HELD : DEBOUNCE;
          end else c <= c + 2'd1;
        DEBOUNCE:
          if (rs[r]) begin
            c <= c + 2'd1;
            st <= SCAN;
          end else if (done) st <= HELD;
          else cnt <= cnt + 1'b1;
        HELD:
          if (rs[r]) begin
            cnt <= '0;
            st <= ONE ? SCAN : RELEASE;
            c <= ONE ? c + 2'd1 : c;
          end
        default:
          if (!rs[r]) st <= HELD;
          else if (done) begin
            c <= c + 2'd1;
            st <= SCAN;
          end else cnt <= cnt + 1'b1;
      endcase
  // a press arriving while the register is full is dropped, keeping the older code
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      key_code_o <= 4'h0;
      key_valid_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (acc && (!key_valid_o || key_ready_i)) key_code_o <= code;
      key_valid_o <= acc || (key_valid_o && !key_ready_i);
      overflow_o <= (acc && key_valid_o && !key_ready_i) || (overflow_o && !clr_overflow_i);
    end
endmodule
